// File: rtl/pattern_101_tx.sv
// Serial frame transmitter: preamble 1,0,1, payload MSB first,
// optional even parity, then a run of trailing zero guard bits.
module pattern_101_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 1,
    parameter int GUARD_BITS = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] iDATA,
    input  logic                  iVALID,
    output logic                  oREADY,
    output logic                  oOUT,
    output logic                  oBUSY,
    output logic                  oDONE
);

    localparam int MAXC = (DATA_WIDTH > GUARD_BITS) ? DATA_WIDTH : GUARD_BITS;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] DATA_LAST  = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        PAR,
        GUARD
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [CW-1:0]           cnt_q;
    logic                    par_q;
    logic                    out_q;
    logic                    done_q;

    // Ready is purely a function of state and reset, never of iVALID.
    assign oREADY = (state_q == IDLE) && reset;
    assign oBUSY  = (state_q != IDLE);
    assign oOUT   = out_q;
    assign oDONE  = done_q;

    // Frame sequencer; every serial bit and the done pulse are registered here.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    out_q <= 1'b0;
                    cnt_q <= '0;
                    if (iVALID) begin
                        shift_q <= iDATA;
                        par_q   <= 1'b0;
                        out_q   <= 1'b1;
                        state_q <= PRE;
                    end
                end
                PRE: begin
                    if (cnt_q == '0) begin
                        out_q <= 1'b0;
                        cnt_q <= CW'(1);
                    end else begin
                        out_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    // Parity accumulates from the captured copy as it shifts out.
                    out_q   <= shift_q[DATA_WIDTH-1];
                    par_q   <= par_q ^ shift_q[DATA_WIDTH-1];
                    shift_q <= shift_q << 1;
                    if (cnt_q == DATA_LAST) begin
                        cnt_q   <= '0;
                        state_q <= (PARITY_EN != 0) ? PAR : GUARD;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                PAR: begin
                    out_q   <= par_q;
                    state_q <= GUARD;
                end
                GUARD: begin
                    out_q <= 1'b0;
                    if (cnt_q == GUARD_LAST) begin
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    out_q   <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
